// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back inputs, ID-stage read ports and
// write-back/debug outputs of the architectural register file.
// master = pipeline side (drives MEM/WB and ID indices), slave = wb_regfile.
interface wb_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) ();
   logic [DATA_WIDTH-1:0] MEM_WB_MemData;
   logic [DATA_WIDTH-1:0] MEM_WB_ALUData;
   logic [ADDR_WIDTH-1:0] MEM_WB_DstReg;
   logic                  MEM_WB_MemtoReg;
   logic                  MEM_WB_RegWrite;
   logic [ADDR_WIDTH-1:0] ID_Rs;
   logic [ADDR_WIDTH-1:0] ID_Rt;
   logic [DATA_WIDTH-1:0] ReadData1;
   logic [DATA_WIDTH-1:0] ReadData2;
   logic [DATA_WIDTH-1:0] WB_Data;
   logic [CNT_WIDTH-1:0]  WB_CommitCount;

   modport master (
      output MEM_WB_MemData, MEM_WB_ALUData, MEM_WB_DstReg,
             MEM_WB_MemtoReg, MEM_WB_RegWrite, ID_Rs, ID_Rt,
      input  ReadData1, ReadData2, WB_Data, WB_CommitCount
   );

   modport slave (
      input  MEM_WB_MemData, MEM_WB_ALUData, MEM_WB_DstReg,
             MEM_WB_MemtoReg, MEM_WB_RegWrite, ID_Rs, ID_Rt,
      output ReadData1, ReadData2, WB_Data, WB_CommitCount
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 2**ADDR_WIDTH-entry register file with two
// asynchronous read ports, and a wrapping count of effective commits.
// Register 0 reads as zero and ignores writes.
// Optional macro WB_BYPASS_EN: same-cycle forwarding of a pending commit to
// the read ports (suppressed while rst is high).
module wb_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input logic          clk,
   input logic          rst,
   wb_regfile_if.slave  bus
);
   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [CNT_WIDTH-1:0]  commit_cnt;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  commit_en;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;

   // Write-back source select; valid whether or not a commit happens.
   always_comb begin
      wb_data = bus.MEM_WB_MemtoReg ? bus.MEM_WB_MemData : bus.MEM_WB_ALUData;
   end

   assign commit_en = bus.MEM_WB_RegWrite && (bus.MEM_WB_DstReg != '0);

   // Register array and commit counter; reset wins over a same-edge commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         commit_cnt <= '0;
      end else if (commit_en) begin
         regs[bus.MEM_WB_DstReg] <= wb_data;
         commit_cnt              <= commit_cnt + CNT_WIDTH'(1);
      end
   end

   // Asynchronous read ports; index 0 always reads zero.
   always_comb begin
      rd1 = (bus.ID_Rs == '0) ? '0 : regs[bus.ID_Rs];
      rd2 = (bus.ID_Rt == '0) ? '0 : regs[bus.ID_Rt];
`ifdef WB_BYPASS_EN
      // commit_en already excludes index 0, so a match implies a nonzero index.
      if (!rst && commit_en && (bus.ID_Rs == bus.MEM_WB_DstReg)) begin
         rd1 = wb_data;
      end
      if (!rst && commit_en && (bus.ID_Rt == bus.MEM_WB_DstReg)) begin
         rd2 = wb_data;
      end
`endif
   end

   assign bus.ReadData1      = rd1;
   assign bus.ReadData2      = rd2;
   assign bus.WB_Data        = wb_data;
   assign bus.WB_CommitCount = commit_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic against an
// array-based reference model of the register file and commit counter.
// Counter width is reduced to 8 bits so wrap-around is reachable.
module tb_wb_regfile;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 8;

   logic clk;
   logic rst;

   wb_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   logic [DW-1:0] model [32];
   int            model_cnt;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   function automatic logic [DW-1:0] exp_wb();
      return bus.MEM_WB_MemtoReg ? bus.MEM_WB_MemData : bus.MEM_WB_ALUData;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
      if (idx == 0) return '0;
      if (BYPASS && !rst && bus.MEM_WB_RegWrite && bus.MEM_WB_DstReg == idx)
         return exp_wb();
      return model[idx];
   endfunction

   // Advance one clock edge and apply the architectural effect to the model.
   task automatic tick();
      logic          do_rst;
      logic          do_commit;
      logic [AW-1:0] d;
      logic [DW-1:0] w;
      do_rst    = rst;
      d         = bus.MEM_WB_DstReg;
      do_commit = bus.MEM_WB_RegWrite && (d != 0);
      w         = exp_wb();
      @(posedge clk);
      #1;
      if (do_rst) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
         model_cnt = 0;
      end else if (do_commit) begin
         model[d]  = w;
         model_cnt = (model_cnt + 1) % (1 << CW);
      end
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic [AW-1:0] dst,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem);
      bus.MEM_WB_RegWrite = rw;
      bus.MEM_WB_MemtoReg = m2r;
      bus.MEM_WB_DstReg   = dst;
      bus.MEM_WB_ALUData  = alu;
      bus.MEM_WB_MemData  = mem;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      rst = 1'b0;
      bus.ID_Rs = 5;
      bus.ID_Rt = 31;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0) begin
         n_mis++; $display("FAIL reset_rd1: got %h want %h", bus.ReadData1, 32'h0);
      end
      n_cmp++;
      if (bus.ReadData2 !== 32'h0) begin
         n_mis++; $display("FAIL reset_rd2: got %h want %h", bus.ReadData2, 32'h0);
      end
      n_cmp++;
      if (bus.WB_CommitCount !== CW'(0)) begin
         n_mis++; $display("FAIL reset_cnt: got %0d want 0", bus.WB_CommitCount);
      end
   endtask

   task automatic test_alu_commit();
      drive(1'b1, 1'b0, 8, 32'h0000_1234, 32'hCAFE_0000);
      bus.ID_Rs = 8;
      #2;
      n_cmp++;
      if (bus.WB_Data !== 32'h0000_1234) begin
         n_mis++; $display("FAIL alu_wbdata: got %h want %h", bus.WB_Data, 32'h0000_1234);
      end
      tick();
      bus.MEM_WB_RegWrite = 1'b0;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0000_1234) begin
         n_mis++; $display("FAIL alu_commit_rd: got %h want %h", bus.ReadData1, 32'h0000_1234);
      end
      n_cmp++;
      if (bus.WB_CommitCount !== CW'(1)) begin
         n_mis++; $display("FAIL alu_commit_cnt: got %0d want 1", bus.WB_CommitCount);
      end
   endtask

   task automatic test_mem_commit_zero();
      drive(1'b1, 1'b1, 9, 32'h1111_2222, 32'hDEAD_BEEF);
      #2;
      n_cmp++;
      if (bus.WB_Data !== 32'hDEAD_BEEF) begin
         n_mis++; $display("FAIL mem_wbdata: got %h want %h", bus.WB_Data, 32'hDEAD_BEEF);
      end
      tick();
      drive(1'b1, 1'b0, 0, 32'h5555_AAAA, 32'h0);
      bus.ID_Rs = 0;
      bus.ID_Rt = 9;
      #2;
      n_cmp++;
      if (bus.ReadData2 !== 32'hDEAD_BEEF) begin
         n_mis++; $display("FAIL mem_commit_rd: got %h want %h", bus.ReadData2, 32'hDEAD_BEEF);
      end
      n_cmp++;
      if (bus.ReadData1 !== 32'h0) begin
         n_mis++; $display("FAIL zero_read_pending: got %h want 0", bus.ReadData1);
      end
      tick();
      bus.MEM_WB_RegWrite = 1'b0;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0) begin
         n_mis++; $display("FAIL zero_read_after: got %h want 0", bus.ReadData1);
      end
      n_cmp++;
      if (bus.WB_CommitCount !== CW'(2)) begin
         n_mis++; $display("FAIL zero_write_cnt: got %0d want 2", bus.WB_CommitCount);
      end
   endtask

   task automatic test_same_cycle();
      logic [DW-1:0] want;
      drive(1'b1, 1'b0, 10, 32'h0000_0001, 32'h0);
      tick();
      drive(1'b1, 1'b0, 10, 32'hA5A5_A5A5, 32'h0);
      bus.ID_Rs = 10;
      bus.ID_Rt = 10;
      #2;
      want = BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001;
      n_cmp++;
      if (bus.ReadData1 !== want) begin
         n_mis++; $display("FAIL same_cycle_rd1: got %h want %h", bus.ReadData1, want);
      end
      n_cmp++;
      if (bus.ReadData2 !== want) begin
         n_mis++; $display("FAIL same_cycle_rd2: got %h want %h", bus.ReadData2, want);
      end
      tick();
      bus.MEM_WB_RegWrite = 1'b0;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'hA5A5_A5A5) begin
         n_mis++; $display("FAIL same_cycle_after: got %h want %h", bus.ReadData1, 32'hA5A5_A5A5);
      end
   endtask

   task automatic test_reset_collision();
      drive(1'b1, 1'b0, 3, 32'h0000_0055, 32'h0);
      tick();
      drive(1'b1, 1'b0, 3, 32'h0000_0077, 32'h0);
      bus.ID_Rs = 3;
      rst = 1'b1;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0000_0055) begin
         n_mis++; $display("FAIL reset_bypass_suppress: got %h want %h", bus.ReadData1, 32'h55);
      end
      tick();
      rst = 1'b0;
      bus.MEM_WB_RegWrite = 1'b0;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0) begin
         n_mis++; $display("FAIL reset_collision_reg: got %h want 0", bus.ReadData1);
      end
      n_cmp++;
      if (bus.WB_CommitCount !== CW'(0)) begin
         n_mis++; $display("FAIL reset_collision_cnt: got %0d want 0", bus.WB_CommitCount);
      end
      // First commit on the first edge with rst low.
      drive(1'b1, 1'b1, 12, 32'h0, 32'h0BAD_F00D);
      bus.ID_Rs = 12;
      tick();
      bus.MEM_WB_RegWrite = 1'b0;
      #2;
      n_cmp++;
      if (bus.ReadData1 !== 32'h0BAD_F00D || bus.WB_CommitCount !== CW'(1)) begin
         n_mis++;
         $display("FAIL post_reset_commit: got %h/%0d want %h/1",
                  bus.ReadData1, bus.WB_CommitCount, 32'h0BAD_F00D);
      end
   endtask

   task automatic test_regwrite_hold();
      int cnt0;
      drive(1'b1, 1'b0, 4, 32'h1111_1111, 32'h0);
      tick();
      cnt0 = model_cnt;
      bus.ID_Rt = 4;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, k[0], 4, 32'hFFFF_FFFF, 32'h0F0F_0000 + k);
         #2;
         n_cmp++;
         if (bus.WB_Data !== exp_wb()) begin
            n_mis++; $display("FAIL hold_wbdata: got %h want %h", bus.WB_Data, exp_wb());
         end
         tick();
      end
      #2;
      n_cmp++;
      if (bus.ReadData2 !== 32'h1111_1111) begin
         n_mis++; $display("FAIL hold_reg: got %h want %h", bus.ReadData2, 32'h1111_1111);
      end
      n_cmp++;
      if (int'(bus.WB_CommitCount) !== cnt0) begin
         n_mis++; $display("FAIL hold_cnt: got %0d want %0d", bus.WB_CommitCount, cnt0);
      end
   endtask

   task automatic test_count_wrap();
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 257; k++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(1, 31)),
               $urandom, $urandom);
         tick();
         if (k == 254 || k == 255 || k == 256) begin
            #2;
            n_cmp++;
            if (int'(bus.WB_CommitCount) !== model_cnt) begin
               n_mis++;
               $display("FAIL count_wrap: got %0d want %0d", bus.WB_CommitCount, model_cnt);
            end
         end
      end
      bus.MEM_WB_RegWrite = 1'b0;
   endtask

   task automatic test_random();
      logic [DW-1:0] e1, e2;
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 31) == 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
               $urandom, $urandom);
         bus.ID_Rs = ($urandom_range(0, 3) == 0) ? bus.MEM_WB_DstReg : AW'($urandom);
         bus.ID_Rt = ($urandom_range(0, 3) == 0) ? bus.MEM_WB_DstReg : AW'($urandom);
         #2;
         e1 = exp_rd(bus.ID_Rs);
         e2 = exp_rd(bus.ID_Rt);
         n_cmp++;
         if (bus.ReadData1 !== e1) begin
            n_mis++; $display("FAIL rand_rd1[%0d] idx %0d: got %h want %h", k, bus.ID_Rs, bus.ReadData1, e1);
         end
         n_cmp++;
         if (bus.ReadData2 !== e2) begin
            n_mis++; $display("FAIL rand_rd2[%0d] idx %0d: got %h want %h", k, bus.ID_Rt, bus.ReadData2, e2);
         end
         n_cmp++;
         if (bus.WB_Data !== exp_wb()) begin
            n_mis++; $display("FAIL rand_wbdata[%0d]: got %h want %h", k, bus.WB_Data, exp_wb());
         end
         n_cmp++;
         if (int'(bus.WB_CommitCount) !== model_cnt) begin
            n_mis++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, bus.WB_CommitCount, model_cnt);
         end
         tick();
      end
      rst = 1'b0;
      bus.MEM_WB_RegWrite = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      model_cnt = 0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      drive(1'b0, 1'b0, '0, '0, '0);
      bus.ID_Rs = '0;
      bus.ID_Rt = '0;
      #2;
      test_reset();
      test_alu_commit();
      test_mem_commit_zero();
      test_same_cycle();
      test_reset_collision();
      test_regwrite_hold();
      test_random();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
